muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative unsigned multiply (radix-2 shift-add) and divide
//            (radix-2 restoring) unit with a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int WIDTH  = 64,
   parameter int OP_DIV = 16,
   parameter int OP_MUL = 17
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       instr,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] rem,
   output logic             divzero
);

   localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_op_div;
   logic [c_CNT_W-1:0]   r_cnt;

   logic                 w_is_div;
   logic                 w_is_mul;
   logic                 w_load;
   logic                 w_dz;
   logic                 w_finish;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_rem_sh;
   logic [WIDTH:0]       w_trial;
   logic [2*WIDTH-1:0]   w_acc_mul;
   logic [2*WIDTH-1:0]   w_acc_div;
   logic [2*WIDTH-1:0]   w_acc_nxt;

   assign w_is_div = (instr == 6'(OP_DIV));
   assign w_is_mul = (instr == 6'(OP_MUL));

   // Multiply: r_acc = {partial product high, multiplier shifting out at bit 0}
   assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
   assign w_acc_mul = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

   // Divide: r_acc = {partial remainder, dividend shifting out / quotient in}
   assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_trial   = w_rem_sh - {1'b0, r_opnd};
   assign w_acc_div = w_trial[WIDTH]
                    ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_trial[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

   assign w_acc_nxt = r_op_div ? w_acc_div : w_acc_mul;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_dz        = 1'b0;
      w_finish    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && w_is_div && (B == '0)) begin
               w_dz        = 1'b1;
               w_state_nxt = S_DONE;
            end else if (start && (w_is_div || w_is_mul)) begin
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == '0) begin
               w_finish    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc    <= '0;
         r_opnd   <= '0;
         r_op_div <= 1'b0;
         r_cnt    <= '0;
         C        <= '0;
         rem      <= '0;
         divzero  <= 1'b0;
      end else if (w_load) begin
         r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? A : B)};
         r_opnd   <= w_is_div ? B : A;
         r_op_div <= w_is_div;
         r_cnt    <= c_CNT_W'(WIDTH - 1);
         divzero  <= 1'b0;
      end else if (w_dz) begin
         C        <= '1;
         rem      <= A;
         divzero  <= 1'b1;
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt - c_CNT_W'(1);
         if (w_finish) begin
            C   <= w_acc_nxt[WIDTH-1:0];
            rem <= w_acc_nxt[2*WIDTH-1:WIDTH];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Directed, table-driven self-checking bench for muldiv_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   localparam int W = 64;

   logic         clock;
   logic         reset;
   logic         start;
   logic [5:0]   instr;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] C;
   logic [W-1:0] rem;
   logic         divzero;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [5:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t vecs[13];

   muldiv_unit #(.WIDTH(W), .OP_DIV(16), .OP_MUL(17)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .instr   (instr),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .C       (C),
      .rem     (rem),
      .divzero (divzero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int cyc;
      bit seen;
      bit busy_ok;
      @(negedge clock);
      instr = v.op;
      A     = v.a;
      B     = v.b;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      // Scramble operands after acceptance; the unit must have latched them.
      A     = {$urandom, $urandom};
      B     = {$urandom, $urandom};
      instr = 6'($urandom);
      cyc     = 1;
      seen    = 1'b0;
      busy_ok = 1'b1;
      while (!seen && cyc <= 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            seen = 1'b1;
         end else begin
            @(posedge clock);
            #1;
            cyc++;
         end
      end
      chk($sformatf("%s done_seen", tag), 128'(seen), 128'(1));
      if (seen) begin
         chk($sformatf("%s latency", tag), 128'(cyc), 128'(v.lat));
         chk($sformatf("%s C", tag), 128'(C), 128'(v.c));
         chk($sformatf("%s rem", tag), 128'(rem), 128'(v.r));
         chk($sformatf("%s divzero", tag), 128'(divzero), 128'(v.dz));
         chk($sformatf("%s busy_held", tag), 128'(busy_ok), 128'(1));
         @(posedge clock);
         #1;
         chk($sformatf("%s idle_busy", tag), 128'(busy), 128'(0));
         chk($sformatf("%s idle_done", tag), 128'(done), 128'(0));
         chk($sformatf("%s C_hold", tag), 128'(C), 128'(v.c));
      end
   endtask

   initial begin
      bit   flag;
      int   n_done;
      int   done_cyc[2];
      vec_t v;

      vecs[0]  = '{6'd17, 64'd12345, 64'd678, 64'd8369910, 64'd0, 1'b0, 65};
      vecs[1]  = '{6'd17, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65};
      vecs[2]  = '{6'd16, 64'd1000, 64'd7, 64'd142, 64'd6, 1'b0, 65};
      vecs[3]  = '{6'd16, 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65};
      vecs[4]  = '{6'd16, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1};
      vecs[5]  = '{6'd17, 64'd3, 64'd4, 64'd12, 64'd0, 1'b0, 65};
      vecs[6]  = '{6'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 65};
      vecs[7]  = '{6'd17, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 65};
      vecs[8]  = '{6'd16, 64'd100, 64'd10, 64'd10, 64'd0, 1'b0, 65};
      vecs[9]  = '{6'd17, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'd2, 1'b0, 65};
      vecs[10] = '{6'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 65};
      vecs[11] = '{6'd16, 64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 65};
      vecs[12] = '{6'd17, 64'hDEAD_BEEF, 64'h1_0000_0000, 64'hDEAD_BEEF_0000_0000, 64'd0, 1'b0, 65};

      reset = 1'b1;
      start = 1'b0;
      instr = '0;
      A     = '0;
      B     = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset busy", 128'(busy), 128'(0));
      chk("reset done", 128'(done), 128'(0));
      chk("reset divzero", 128'(divzero), 128'(0));
      chk("reset C", 128'(C), 128'(0));
      chk("reset rem", 128'(rem), 128'(0));
      @(negedge clock);
      reset = 1'b0;

      // Unsupported opcodes are ignored
      @(negedge clock);
      start = 1'b1;
      instr = 6'd0;
      A     = 64'd5;
      B     = 64'd5;
      flag  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         if (busy !== 1'b0 || done !== 1'b0) flag = 1'b0;
         instr = 6'd18;
      end
      start = 1'b0;
      chk("bad_instr ignored", 128'(flag), 128'(1));

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // start held high through two back-to-back multiplies
      @(negedge clock);
      instr = 6'd17;
      A     = 64'd2;
      B     = 64'd3;
      start = 1'b1;
      n_done = 0;
      done_cyc[0] = 0;
      done_cyc[1] = 0;
      for (int cyc = 1; cyc <= 140; cyc++) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) begin
            if (n_done < 2) done_cyc[n_done] = cyc;
            n_done++;
            if (n_done == 1) begin
               chk("held first C", 128'(C), 128'(6));
               A = 64'd7;
               B = 64'd6;
            end else begin
               chk("held second C", 128'(C), 128'(42));
            end
         end
         if (cyc == 66) chk("held gap busy", 128'(busy), 128'(0));
         if (cyc == 67) begin
            chk("held second busy", 128'(busy), 128'(1));
            start = 1'b0;
         end
      end
      chk("held done count", 128'(n_done), 128'(2));
      chk("held first done cycle", 128'(done_cyc[0]), 128'(65));
      chk("held second done cycle", 128'(done_cyc[1]), 128'(131));

      // Reset mid-operation aborts without done
      @(negedge clock);
      instr = 6'd16;
      A     = 64'd1000;
      B     = 64'd7;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (19) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("midreset busy", 128'(busy), 128'(0));
      chk("midreset done", 128'(done), 128'(0));
      chk("midreset C", 128'(C), 128'(0));
      chk("midreset rem", 128'(rem), 128'(0));
      @(negedge clock);
      reset = 1'b0;
      flag  = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(posedge clock);
         #1;
         if (done !== 1'b0 || busy !== 1'b0) flag = 1'b0;
      end
      chk("midreset no_done", 128'(flag), 128'(1));
      v = '{6'd17, 64'd9, 64'd9, 64'd81, 64'd0, 1'b0, 65};
      run_op(v, "post_reset 9x9");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
